// File: rtl/my_sc_fifo.sv
// Single-clock 256 x 16 FIFO in normal (non-show-ahead) mode with registered
// read data, registered fill level and flags, and overflow/underflow protection.
module my_sc_fifo #(
  parameter int DATA_WIDTH         = 16,
  parameter int DEPTH              = 256,
  parameter int ADDR_WIDTH         = $clog2(DEPTH),
  parameter int ALMOST_FULL_VALUE  = 240,
  parameter int ALMOST_EMPTY_VALUE = 16
) (
  input  logic                  clock,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH-1:0] usedw,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_AFULL = (ADDR_WIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [ADDR_WIDTH:0]   LVL_AEMPT = (ADDR_WIDTH+1)'(ALMOST_EMPTY_VALUE);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  wr_en;
  logic                  rd_en;

  // Flags are registered, so the acceptance gates use last cycle's full/empty.
  assign wr_en = wrreq & ~full & ~sclr;
  assign rd_en = rdreq & ~empty & ~sclr;

  always_comb begin
    level_next = level;
    unique case ({wr_en, rd_en})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      q <= '0;
    end else if (rd_en) begin
      q <= mem[rptr];
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + PTR_ONE;
      if (rd_en)
        rptr <= rptr + PTR_ONE;
      level <= level_next;
    end
  end

  // Status outputs track the post-edge level; usedw wraps to 0 when full.
  always_ff @(posedge clock) begin
    if (sclr) begin
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      usedw        <= level_next[ADDR_WIDTH-1:0];
      empty        <= (level_next == '0);
      full         <= (level_next == LVL_FULL);
      almost_empty <= (level_next < LVL_AEMPT);
      almost_full  <= (level_next >= LVL_AFULL);
    end
  end

endmodule

// File: tb/tb_my_sc_fifo.sv
// Directed self-checking bench for my_sc_fifo: reset, fill, overflow, drain,
// underflow/simultaneous access, mid-operation clear and read+write while full.
module tb_my_sc_fifo;

  logic        clock;
  logic        sclr;
  logic [15:0] data;
  logic        wrreq;
  logic        rdreq;
  logic [15:0] q;
  logic [7:0]  usedw;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;

  int vectors;
  int miscompares;

  my_sc_fifo dut (
    .clock       (clock),
    .sclr        (sclr),
    .data        (data),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .q           (q),
    .usedw       (usedw),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic test_reset;
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = 16'h0;
    repeat (2) @(negedge clock);
    sclr = 1'b0;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b, expected 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b, expected 0", full); end
    vectors++; if (usedw !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_usedw: got %0d, expected 0", usedw); end
    vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_aempty: got %b, expected 1", almost_empty); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_afull: got %b, expected 0", almost_full); end
    vectors++; if (q !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_q: got %h, expected 0000", q); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 256; i++) begin
      int lvl;
      lvl = i + 1;
      wrreq = 1'b1; data = 16'(i);
      @(negedge clock);
      vectors++; if (usedw !== 8'(lvl)) begin miscompares++; $display("[TB] FAIL fill_usedw[%0d]: got %0d, expected %0d", i, usedw, lvl % 256); end
      vectors++; if (full !== (lvl == 256)) begin miscompares++; $display("[TB] FAIL fill_full[%0d]: got %b, expected %b", i, full, lvl == 256); end
      vectors++; if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_empty[%0d]: got %b, expected 0", i, empty); end
      vectors++; if (almost_empty !== (lvl < 16)) begin miscompares++; $display("[TB] FAIL fill_aempty[%0d]: got %b, expected %b", i, almost_empty, lvl < 16); end
      vectors++; if (almost_full !== (lvl >= 240)) begin miscompares++; $display("[TB] FAIL fill_afull[%0d]: got %b, expected %b", i, almost_full, lvl >= 240); end
    end
    wrreq = 1'b0;
  endtask

  task automatic test_overflow;
    wrreq = 1'b1; data = 16'hBEEF;
    @(negedge clock);
    wrreq = 1'b0;
    vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_full: got %b, expected 1", full); end
    vectors++; if (usedw !== 8'd0) begin miscompares++; $display("[TB] FAIL ovf_usedw: got %0d, expected 0", usedw); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 256; i++) begin
      rdreq = 1'b1;
      @(negedge clock);
      vectors++; if (q !== 16'(i)) begin miscompares++; $display("[TB] FAIL drain_q[%0d]: got %h, expected %h", i, q, 16'(i)); end
      vectors++; if (usedw !== 8'(255 - i)) begin miscompares++; $display("[TB] FAIL drain_usedw[%0d]: got %0d, expected %0d", i, usedw, 255 - i); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_full[%0d]: got %b, expected 0", i, full); end
      vectors++; if (empty !== (i == 255)) begin miscompares++; $display("[TB] FAIL drain_empty[%0d]: got %b, expected %b", i, empty, i == 255); end
    end
    rdreq = 1'b0;
  endtask

  task automatic test_underflow_simul;
    rdreq = 1'b1; wrreq = 1'b0;
    @(negedge clock);
    vectors++; if (q !== 16'h00FF) begin miscompares++; $display("[TB] FAIL unf_q: got %h, expected 00ff", q); end
    vectors++; if (usedw !== 8'd0) begin miscompares++; $display("[TB] FAIL unf_usedw: got %0d, expected 0", usedw); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_empty: got %b, expected 1", empty); end
    wrreq = 1'b1; data = 16'h1234;
    @(negedge clock);
    vectors++; if (usedw !== 8'd1) begin miscompares++; $display("[TB] FAIL simul_empty_usedw: got %0d, expected 1", usedw); end
    vectors++; if (q !== 16'h00FF) begin miscompares++; $display("[TB] FAIL simul_empty_q: got %h, expected 00ff", q); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_empty_empty: got %b, expected 0", empty); end
    data = 16'h5678;
    @(negedge clock);
    vectors++; if (q !== 16'h1234) begin miscompares++; $display("[TB] FAIL simul_q: got %h, expected 1234", q); end
    vectors++; if (usedw !== 8'd1) begin miscompares++; $display("[TB] FAIL simul_usedw: got %0d, expected 1", usedw); end
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic test_mid_clear;
    // One word (0x5678) is still queued from the previous scenario.
    for (int i = 0; i < 10; i++) begin
      wrreq = 1'b1; data = 16'hA000 + 16'(i);
      @(negedge clock);
    end
    vectors++; if (usedw !== 8'd11) begin miscompares++; $display("[TB] FAIL clr_pre_usedw: got %0d, expected 11", usedw); end
    sclr = 1'b1; data = 16'hDEAD;
    @(negedge clock);
    sclr = 1'b0;
    vectors++; if (usedw !== 8'd0) begin miscompares++; $display("[TB] FAIL clr_usedw: got %0d, expected 0", usedw); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_empty: got %b, expected 1", empty); end
    vectors++; if (q !== 16'h0) begin miscompares++; $display("[TB] FAIL clr_q: got %h, expected 0000", q); end
    data = 16'hCAFE;
    @(negedge clock);
    vectors++; if (usedw !== 8'd1) begin miscompares++; $display("[TB] FAIL clr_wr_usedw: got %0d, expected 1", usedw); end
    wrreq = 1'b0; rdreq = 1'b1;
    @(negedge clock);
    rdreq = 1'b0;
    vectors++; if (q !== 16'hCAFE) begin miscompares++; $display("[TB] FAIL clr_rd_q: got %h, expected cafe", q); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_rd_empty: got %b, expected 1", empty); end
  endtask

  task automatic test_full_simul;
    for (int i = 0; i < 256; i++) begin
      wrreq = 1'b1; data = 16'h3000 + 16'(i);
      @(negedge clock);
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fs_pre_full: got %b, expected 1", full); end
    rdreq = 1'b1; data = 16'hFFFF;
    @(negedge clock);
    vectors++; if (q !== 16'h3000) begin miscompares++; $display("[TB] FAIL fs_q: got %h, expected 3000", q); end
    vectors++; if (usedw !== 8'd255) begin miscompares++; $display("[TB] FAIL fs_usedw: got %0d, expected 255", usedw); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL fs_full: got %b, expected 0", full); end
    data = 16'h7777;
    @(negedge clock);
    vectors++; if (q !== 16'h3001) begin miscompares++; $display("[TB] FAIL b2b_q: got %h, expected 3001", q); end
    vectors++; if (usedw !== 8'd255) begin miscompares++; $display("[TB] FAIL b2b_usedw: got %0d, expected 255", usedw); end
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = 16'h0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow_simul();
    test_mid_clear();
    test_full_simul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
